// File: rtl/bram_lane_accumulator_pkg.sv
// Shared types and lane helpers for the BRAM lane accumulator.
// Build option: ACC_SATURATE_EN makes lane sums saturate instead of wrap.
package bram_lane_accumulator_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_FLUSH = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam int STATE_W = 3;

   function automatic int lane_lo(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/bram_lane_accumulator_if.sv
// BRAM0/BRAM1 port bundle between the accumulator and the two memories.
// The accumulator is the master and drives address, enable and write data.
interface bram_lane_accumulator_if #(
   parameter int AWIDTH   = 8,
   parameter int DWIDTH_1 = 32,
   parameter int DWIDTH_2 = 64
);

   logic [AWIDTH-1:0]   addr_b0_o;
   logic                ce_b0_o;
   logic                we_b0_o;
   logic [DWIDTH_1-1:0] d_b0_o;
   logic [DWIDTH_1-1:0] q_b0_i;

   logic [AWIDTH-1:0]   addr_b1_o;
   logic                ce_b1_o;
   logic                we_b1_o;
   logic [DWIDTH_2-1:0] d_b1_o;
   logic [DWIDTH_2-1:0] q_b1_i;

   modport master (
      output addr_b0_o, ce_b0_o, we_b0_o, d_b0_o,
      input  q_b0_i,
      output addr_b1_o, ce_b1_o, we_b1_o, d_b1_o,
      input  q_b1_i
   );

   modport slave (
      input  addr_b0_o, ce_b0_o, we_b0_o, d_b0_o,
      output q_b0_i,
      input  addr_b1_o, ce_b1_o, we_b1_o, d_b1_o,
      output q_b1_i
   );

endinterface

// File: rtl/bram_lane_acc.sv
// One unsigned lane accumulator; wraps by default, saturates with
// ACC_SATURATE_EN defined.
module bram_lane_acc #(
   parameter int IN_W  = 8,
   parameter int ACC_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             enable,
   input  logic [IN_W-1:0]  data,
   output logic [ACC_W-1:0] sum
);

   logic [ACC_W-1:0] nxt_w;

`ifdef ACC_SATURATE_EN
   logic [ACC_W:0] add_w;

   assign add_w = {1'b0, sum} + (ACC_W+1)'(data);
   assign nxt_w = add_w[ACC_W] ? '1 : add_w[ACC_W-1:0];
`else
   assign nxt_w = sum + ACC_W'(data);
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sum <= '0;
      end else if (clear) begin
         sum <= '0;
      end else if (enable) begin
         sum <= nxt_w;
      end
   end

endmodule

// File: rtl/bram_lane_accumulator.sv
// Streams N words from BRAM0, sums each lane, writes one packed result
// word to BRAM1. Build option: ACC_SATURATE_EN (saturating lane sums).
module bram_lane_accumulator
   import bram_lane_accumulator_pkg::*;
#(
   parameter int CNT_BIT       = 31,
   parameter int NUM_LANE      = 4,
   parameter int IN_DATA_WIDTH = 8,
   parameter int ACC_WIDTH     = 16,
   parameter int AWIDTH        = 8,
   parameter int DWIDTH_1      = NUM_LANE * IN_DATA_WIDTH,
   parameter int DWIDTH_2      = NUM_LANE * ACC_WIDTH
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start_run_i,
   input  logic [CNT_BIT-1:0] run_count_i,
   input  logic [AWIDTH-1:0]  rd_base_i,
   input  logic [AWIDTH-1:0]  wr_addr_i,
   output logic               idle_o,
   output logic               read_o,
   output logic               write_o,
   output logic               done_o,
   bram_lane_accumulator_if.master bram
);

   state_t             state;
   logic [CNT_BIT-1:0] cnt_q;
   logic [CNT_BIT-1:0] k_q;
   logic [AWIDTH-1:0]  base_q;
   logic [AWIDTH-1:0]  wr_q;
   logic [AWIDTH-1:0]  addr0_q;
   logic [AWIDTH-1:0]  addr1_q;
   logic               ce0_q;
   logic               ce1_q;
   logic               we1_q;
   logic               rd_vld_q;
   logic               clear_w;
   logic [DWIDTH_2-1:0] sum_w;

   assign clear_w = (state == ST_IDLE) && start_run_i;

   assign bram.addr_b0_o = addr0_q;
   assign bram.ce_b0_o   = ce0_q;
   assign bram.we_b0_o   = 1'b0;
   assign bram.d_b0_o    = '0;
   assign bram.addr_b1_o = addr1_q;
   assign bram.ce_b1_o   = ce1_q;
   assign bram.we_b1_o   = we1_q;
   assign bram.d_b1_o    = sum_w;

   // rd_vld_q marks the cycle in which q_b0_i carries last cycle's read
   for (genvar i = 0; i < NUM_LANE; i++) begin : g_lane
      bram_lane_acc #(
         .IN_W  (IN_DATA_WIDTH),
         .ACC_W (ACC_WIDTH)
      ) u_acc (
         .clk     (clk),
         .reset_n (reset_n),
         .clear   (clear_w),
         .enable  (rd_vld_q),
         .data    (bram.q_b0_i[lane_lo(i, IN_DATA_WIDTH) +: IN_DATA_WIDTH]),
         .sum     (sum_w[lane_lo(i, ACC_WIDTH) +: ACC_WIDTH])
      );
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         cnt_q    <= '0;
         k_q      <= '0;
         base_q   <= '0;
         wr_q     <= '0;
         addr0_q  <= '0;
         addr1_q  <= '0;
         ce0_q    <= 1'b0;
         ce1_q    <= 1'b0;
         we1_q    <= 1'b0;
         rd_vld_q <= 1'b0;
         idle_o   <= 1'b1;
         read_o   <= 1'b0;
         write_o  <= 1'b0;
         done_o   <= 1'b0;
      end else begin
         rd_vld_q <= read_o;
         unique case (state)
            ST_IDLE: begin
               if (start_run_i) begin
                  cnt_q  <= run_count_i;
                  base_q <= rd_base_i;
                  wr_q   <= wr_addr_i;
                  k_q    <= '0;
                  idle_o <= 1'b0;
                  if (run_count_i != '0) begin
                     state   <= ST_RUN;
                     read_o  <= 1'b1;
                     ce0_q   <= 1'b1;
                     addr0_q <= rd_base_i;
                  end else begin
                     state  <= ST_DONE;
                     done_o <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (k_q == cnt_q - CNT_BIT'(1)) begin
                  state   <= ST_FLUSH;
                  read_o  <= 1'b0;
                  ce0_q   <= 1'b0;
                  addr0_q <= '0;
               end else begin
                  k_q     <= k_q + CNT_BIT'(1);
                  addr0_q <= base_q + AWIDTH'(k_q + CNT_BIT'(1));
               end
            end
            ST_FLUSH: begin
               state   <= ST_WRITE;
               write_o <= 1'b1;
               ce1_q   <= 1'b1;
               we1_q   <= 1'b1;
               addr1_q <= wr_q;
            end
            ST_WRITE: begin
               state   <= ST_DONE;
               write_o <= 1'b0;
               ce1_q   <= 1'b0;
               we1_q   <= 1'b0;
               addr1_q <= '0;
               done_o  <= 1'b1;
            end
            ST_DONE: begin
               state  <= ST_IDLE;
               done_o <= 1'b0;
               idle_o <= 1'b1;
            end
            default: begin
               state  <= ST_IDLE;
               idle_o <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bram_lane_accumulator.sv
// Directed bench for bram_lane_accumulator with BRAM0/BRAM1 models.
// Overflow expectation follows the ACC_SATURATE_EN build option.
module tb_bram_lane_accumulator;

   localparam int CNT_BIT       = 31;
   localparam int NUM_LANE      = 4;
   localparam int IN_DATA_WIDTH = 8;
   localparam int ACC_WIDTH     = 16;
   localparam int AWIDTH        = 8;
   localparam int DWIDTH_1      = 32;
   localparam int DWIDTH_2      = 64;

`ifdef ACC_SATURATE_EN
   localparam logic [63:0] OVF_EXP = 64'hFFFF_FFFF_FFFF_FFFF;
`else
   localparam logic [63:0] OVF_EXP = 64'h2AD4_2AD4_2AD4_2AD4;
`endif

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic               start_run_i = 1'b0;
   logic [CNT_BIT-1:0] run_count_i = '0;
   logic [AWIDTH-1:0]  rd_base_i = '0;
   logic [AWIDTH-1:0]  wr_addr_i = '0;
   logic               idle_o;
   logic               read_o;
   logic               write_o;
   logic               done_o;

   bram_lane_accumulator_if #(
      .AWIDTH   (AWIDTH),
      .DWIDTH_1 (DWIDTH_1),
      .DWIDTH_2 (DWIDTH_2)
   ) bram ();

   bram_lane_accumulator #(
      .CNT_BIT       (CNT_BIT),
      .NUM_LANE      (NUM_LANE),
      .IN_DATA_WIDTH (IN_DATA_WIDTH),
      .ACC_WIDTH     (ACC_WIDTH),
      .AWIDTH        (AWIDTH),
      .DWIDTH_1      (DWIDTH_1),
      .DWIDTH_2      (DWIDTH_2)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start_run_i (start_run_i),
      .run_count_i (run_count_i),
      .rd_base_i   (rd_base_i),
      .wr_addr_i   (wr_addr_i),
      .idle_o      (idle_o),
      .read_o      (read_o),
      .write_o     (write_o),
      .done_o      (done_o),
      .bram        (bram)
   );

   logic [DWIDTH_1-1:0] mem0 [256];
   logic [DWIDTH_2-1:0] mem1 [256];
   logic [DWIDTH_1-1:0] q0 = '0;

   int tests = 0;
   int fails = 0;
   int done_c, wr_c, nwr, nce0, nce1;
   logic [AWIDTH-1:0] aseq [$];

   always #5 clk = ~clk;

   assign bram.q_b0_i = q0;
   assign bram.q_b1_i = '0;

   always @(posedge clk) begin
      if (bram.ce_b0_o) q0 <= mem0[bram.addr_b0_o];
      if (bram.ce_b1_o && bram.we_b1_o) mem1[bram.addr_b1_o] <= bram.d_b1_o;
   end

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Cycle c counts posedges after the start-sampling edge; signals are
   // sampled on the negedge just before edge c.
   task automatic do_run(input int n, input logic [7:0] base,
                         input logic [7:0] wa, input int inj);
      aseq.delete();
      done_c = -1; wr_c = -1; nwr = 0; nce0 = 0; nce1 = 0;
      @(negedge clk);
      start_run_i = 1'b1;
      run_count_i = CNT_BIT'(n);
      rd_base_i   = base;
      wr_addr_i   = wa;
      @(posedge clk);
      #1;
      start_run_i = 1'b0;
      run_count_i = CNT_BIT'($urandom);
      rd_base_i   = AWIDTH'($urandom);
      wr_addr_i   = AWIDTH'($urandom);
      for (int c = 1; c <= n + 20; c++) begin
         @(negedge clk);
         start_run_i = (c == inj);
         if (bram.ce_b0_o) begin
            nce0++;
            aseq.push_back(bram.addr_b0_o);
         end
         if (bram.ce_b1_o) nce1++;
         if (bram.we_b1_o) begin
            nwr++;
            wr_c = c;
         end
         if (done_o) begin
            done_c = c;
            break;
         end
      end
      start_run_i = 1'b0;
      if (done_c < 0) check("done_timeout", 64'd0, 64'd1);
   endtask

   function automatic logic [63:0] pack_aseq();
      logic [63:0] v = '0;
      for (int i = 0; i < aseq.size(); i++) v = (v << 8) | 64'(aseq[i]);
      return v;
   endfunction

   task automatic check_reset_vals(input string tag);
      check({tag, "_flags"}, {60'd0, idle_o, read_o, write_o, done_o},
            64'h8);
      check({tag, "_b0"}, {bram.addr_b0_o, bram.ce_b0_o, bram.we_b0_o,
                           bram.d_b0_o}, 64'd0);
      check({tag, "_b1"}, {bram.addr_b1_o, bram.ce_b1_o, bram.we_b1_o},
            64'd0);
      check({tag, "_d1"}, bram.d_b1_o, 64'd0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem0[i] = '0;
         mem1[i] = '0;
      end
      repeat (2) @(negedge clk);
      check_reset_vals("rst");
      reset_n = 1'b1;

      // wrap arithmetic, base 0x10
      for (int i = 16; i < 20; i++) mem0[i] = 32'h0403_0201;
      do_run(4, 8'h10, 8'h05, 0);
      check("t1_addr", pack_aseq(), 64'h1011_1213);
      check("t1_wr_c", 64'(wr_c), 64'd6);
      check("t1_done_c", 64'(done_c), 64'd7);
      check("t1_nwr", 64'(nwr), 64'd1);
      check("t1_res", mem1[5], 64'h0010_000C_0008_0004);

      // back-to-back with fresh accumulators
      mem0[32] = 32'h0101_0101;
      mem0[33] = 32'h0202_0202;
      do_run(2, 8'h20, 8'h06, 0);
      check("b2b_done_c", 64'(done_c), 64'd5);
      check("b2b_res", mem1[6], 64'h0003_0003_0003_0003);

      // zero count
      do_run(0, 8'h40, 8'h07, 0);
      check("z_done_c", 64'(done_c), 64'd1);
      check("z_nce", 64'({nce0[15:0], nce1[15:0]}), 64'd0);

      // address wrap
      mem0[254] = 32'h1122_3344;
      mem0[255] = 32'h0101_0101;
      mem0[0]   = 32'h1020_3040;
      mem0[1]   = 32'h0000_0005;
      do_run(4, 8'hFE, 8'h08, 0);
      check("aw_addr", pack_aseq(), 64'hFEFF_0001);
      check("aw_res", mem1[8], 64'h0022_0043_0064_008A);

      // start pulse during RUN is ignored
      do_run(4, 8'h10, 8'h09, 2);
      check("ign_nwr", 64'(nwr), 64'd1);
      check("ign_res", mem1[9], 64'h0010_000C_0008_0004);
      nce0 = 0;
      repeat (6) begin
         @(negedge clk);
         if (bram.ce_b0_o || bram.ce_b1_o) nce0++;
      end
      check("ign_quiet", 64'(nce0), 64'd0);
      check("ign_idle", 64'(idle_o), 64'd1);

      // reset during RUN cycle 2
      @(negedge clk);
      start_run_i = 1'b1;
      run_count_i = 31'd4;
      rd_base_i   = 8'h10;
      wr_addr_i   = 8'h0A;
      @(posedge clk);
      #1;
      start_run_i = 1'b0;
      repeat (3) @(negedge clk);
      check("mr_pre_d1", 64'(bram.d_b1_o != '0), 64'd1);
      reset_n = 1'b0;
      #1;
      check_reset_vals("mr");
      @(negedge clk);
      reset_n = 1'b1;
      nwr = 0;
      repeat (10) begin
         @(negedge clk);
         if (bram.we_b1_o || bram.ce_b0_o) nwr++;
      end
      check("mr_nowrite", 64'(nwr), 64'd0);
      check("mr_mem1", mem1[10], 64'd0);

      // overflow with 300 all-ones words
      for (int i = 0; i < 256; i++) mem0[i] = 32'hFFFF_FFFF;
      do_run(300, 8'h00, 8'h0B, 0);
      check("ov_done_c", 64'(done_c), 64'd303);
      check("ov_res", mem1[11], OVF_EXP);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bram_lane_accumulator.md
Name: bram_lane_accumulator

Overview:
- Parametrised successor to the single-BRAM reader. Streams `run_count_i` packed words from BRAM0 starting at a programmable base address.
- Splits each word into NUM_LANE unsigned lanes and accumulates each lane independently.
- Writes one packed result word (NUM_LANE sums) to BRAM1 at a programmable address.
- Sits between the control register block and the two BRAMs. Status is exposed via idle/read/write/done.

Parameters:
- CNT_BIT, 31, width of run_count_i and the internal counter
- NUM_LANE, 4, number of lanes per BRAM0 word
- IN_DATA_WIDTH, 8, width of one input lane
- ACC_WIDTH, 16, width of one lane accumulator
- AWIDTH, 8, BRAM address width
- DWIDTH_1, NUM_LANE*IN_DATA_WIDTH, BRAM0 data width
- DWIDTH_2, NUM_LANE*ACC_WIDTH, BRAM1 data width

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- start_run_i  input  1  start pulse; sampled only in IDLE
- run_count_i  input  CNT_BIT  number of BRAM0 words to read
- rd_base_i  input  AWIDTH  first BRAM0 address
- wr_addr_i  input  AWIDTH  BRAM1 result address
- q_b0_i  input  DWIDTH_1  BRAM0 read data, 1-cycle latency
- q_b1_i  input  DWIDTH_2  BRAM1 read data; unused in this block
- idle_o, read_o, write_o, done_o  output  1 each  state flags
- addr_b0_o  output  AWIDTH; ce_b0_o, we_b0_o  output  1; d_b0_o  output  DWIDTH_1  BRAM0 interface
- addr_b1_o  output  AWIDTH; ce_b1_o, we_b1_o  output  1; d_b1_o  output  DWIDTH_2  BRAM1 interface

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values:
  - State is IDLE, so idle_o=1.
  - All other flags are 0.
  - All ce/we are 0, all addresses are 0, d_b0_o=0.
  - Accumulators and d_b1_o are 0.
  - Captured count, base and write address are 0.
- States: IDLE, RUN, FLUSH, WRITE, DONE.
- IDLE:
  - On start_run_i=1, capture run_count_i, rd_base_i and wr_addr_i, and clear all accumulators.
  - Go to RUN if the count is nonzero, otherwise go to DONE.
- RUN, cycle k (k=0..N-1):
  - Drive addr_b0_o = rd_base+k (mod 2^AWIDTH, wraps silently), ce_b0_o=1, read_o=1.
  - Register a read-valid flag.
  - Leave after cycle k=N-1 and go to FLUSH.
- Accumulation:
  - In each cycle where read-valid=1 (RUN cycles 1..N-1 and FLUSH), lane i adds zero-extended q_b0_i[i*IN_DATA_WIDTH +: IN_DATA_WIDTH] into its accumulator.
  - Default arithmetic wraps modulo 2^ACC_WIDTH.
- FLUSH: absorbs the last read word, then goes to WRITE.
- WRITE (one cycle):
  - ce_b1_o=1, we_b1_o=1, addr_b1_o=wr_addr, write_o=1.
  - d_b1_o = concatenation of the accumulators, lane 0 in the LSBs.
- DONE: done_o=1 for one cycle, then IDLE.
- Latency: for N>0, WRITE occurs N+2 cycles and done_o N+3 cycles after the start-sampling edge. For N=0, done_o occurs 1 cycle after it with no BRAM access.
- Fixed outputs: we_b0_o=0 and d_b0_o=0 always.
- Bus defaults: ce/addr of a BRAM return to 0 when that BRAM is not accessed. d_b1_o holds the accumulator value.
- start_run_i outside IDLE is ignored. Inputs may change freely after capture.
- Reset mid-operation aborts immediately: no BRAM1 write is issued and all values return to reset values.

Optional Feature:
- Macro: ACC_SATURATE_EN.
- When defined, each lane add saturates at 2^ACC_WIDTH-1 and stays there.
- When undefined, lane adds wrap modulo 2^ACC_WIDTH.

Decomposition:
- Shared package bram_lane_accumulator_pkg holds:
  - state encoding localparams (IDLE=0, RUN=1, FLUSH=2, WRITE=3, DONE=4, 3 bits)
  - lane slicing helper constants
- One natural sub-module, bram_lane_acc, one per lane via generate:
  - inputs: clear, enable, data
  - output: registered sum
  - contains the saturate/wrap logic

Test Plan:
- Wrap arithmetic: N=4, base=0x10, BRAM0[0x10..0x13]=0x04030201 each, wr_addr=0x05 -> addr_b0 0x10..0x13 in RUN; BRAM1[0x05]=0x0010_000C_0008_0004; done_o at start+7.
- Zero count: N=0 -> done_o one cycle after start; ce_b0_o, ce_b1_o never asserted.
- Address wrap: base=0xFE, N=4 -> addr_b0 sequence 0xFE, 0xFF, 0x00, 0x01; sums match these four words.
- Overflow: all lanes 0xFF, N=300, ACC_WIDTH=16 -> each lane 0x2AD4 (76500 mod 65536); with ACC_SATURATE_EN and N=300, ACC_WIDTH=8 -> each lane 0xFF.
- Reset and start during run: reset_n low during RUN cycle 2 -> all outputs at reset values, no we_b1_o pulse; start_run_i pulsed during RUN -> ignored, single WRITE.
- Back-to-back runs: second start issued in the cycle after DONE -> accumulators cleared; second result independent of the first.
